// File: rtl/av_slave_fft_loader_pkg.sv
// rtl/av_slave_fft_loader_pkg.sv - shared widths, address map and helpers for the FFT loader slave
package av_slave_pkg;

  localparam int ADDR_W      = 9;
  localparam int DATA_W      = 32;
  localparam int SAMPLE_W    = 16;
  localparam int NUM_SAMPLES = 256;
  localparam int START_BIT   = 16;
  localparam int CNT_W       = $clog2(NUM_SAMPLES + 1);

  localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(NUM_SAMPLES);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(NUM_SAMPLES);

  function automatic logic is_sample_addr(input logic [ADDR_W-1:0] addr);
    return addr < CTRL_ADDR;
  endfunction

endpackage

// File: rtl/av_slave_fft_loader_write_edge.sv
// rtl/av_slave_fft_loader_write_edge.sv - turns a held write request into a single-cycle accept pulse
module av_write_edge (
  input  logic clk,
  input  logic n_rst,
  input  logic wr_req,
  output logic accept
);

  logic wr_req_q;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_req_q <= 1'b0;
    end else begin
      wr_req_q <= wr_req;
    end
  end

  // Clearing the history in reset makes a request held across release count as new.
  assign accept = wr_req & ~wr_req_q;

endmodule

// File: rtl/av_slave_fft_loader.sv
// rtl/av_slave_fft_loader.sv - Avalon-MM write slave feeding FFT sample memory; AV_SLAVE_AUTO_START_EN adds auto start
module av_slave_fft_loader
  import av_slave_pkg::*;
(
  input  logic                clk,
  input  logic                n_rst,
  input  logic                slave_chipselect,
  input  logic                slave_read,
  input  logic                slave_write,
  input  logic [ADDR_W-1:0]   slave_address,
  input  logic [DATA_W-1:0]   slave_writedata,
  output logic                sWriteEn,
  output logic [ADDR_W-1:0]   wAddress,
  output logic [SAMPLE_W-1:0] fft_init_data,
  output logic                fft_start
);

  logic             wr_req;
  logic             accept;
  logic [CNT_W-1:0] sample_cnt;
  logic             unused_ok;

  assign wr_req    = slave_chipselect & slave_write;
  assign unused_ok = ^{slave_read, slave_writedata[DATA_W-1:START_BIT+1]};

  av_write_edge u_write_edge (
    .clk    (clk),
    .n_rst  (n_rst),
    .wr_req (wr_req),
    .accept (accept)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sWriteEn      <= 1'b0;
      wAddress      <= '0;
      fft_init_data <= '0;
      fft_start     <= 1'b0;
      sample_cnt    <= '0;
    end else begin
      sWriteEn  <= 1'b0;
      fft_start <= 1'b0;

      if (accept && is_sample_addr(slave_address)) begin
        sWriteEn      <= 1'b1;
        wAddress      <= slave_address;
        fft_init_data <= slave_writedata[SAMPLE_W-1:0];
        if (sample_cnt != CNT_FULL) begin
          sample_cnt <= sample_cnt + 1'b1;
        end
      end

`ifdef AV_SLAVE_AUTO_START_EN
      // Counter reaches full on the write's strobe cycle, so the start lands one cycle later.
      if (sample_cnt == CNT_FULL) begin
        fft_start  <= 1'b1;
        sample_cnt <= '0;
      end
`endif

      if (accept && (slave_address == CTRL_ADDR) && slave_writedata[START_BIT]) begin
        fft_start  <= 1'b1;
        sample_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_av_slave_fft_loader.sv
// tb/tb_av_slave_fft_loader.sv - directed self-checking bench for av_slave_fft_loader
module tb_av_slave_fft_loader;

`ifdef AV_SLAVE_AUTO_START_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        n_rst;
  logic        slave_chipselect;
  logic        slave_read;
  logic        slave_write;
  logic [8:0]  slave_address;
  logic [31:0] slave_writedata;
  logic        sWriteEn;
  logic [8:0]  wAddress;
  logic [15:0] fft_init_data;
  logic        fft_start;

  int n_checks = 0;
  int n_errors = 0;
  int we_cnt, st_cnt, we_at, st_at;

  av_slave_fft_loader dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .slave_chipselect (slave_chipselect),
    .slave_read       (slave_read),
    .slave_write      (slave_write),
    .slave_address    (slave_address),
    .slave_writedata  (slave_writedata),
    .sWriteEn         (sWriteEn),
    .wAddress         (wAddress),
    .fft_init_data    (fft_init_data),
    .fft_start        (fft_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_bus();
    slave_chipselect = 1'b0;
    slave_read       = 1'b0;
    slave_write      = 1'b0;
  endtask

  // Holds the bus request for 'hold' cycles then idles 3; reports pulse counts and the
  // cycle index (0 = first edge after the request appears) of the first pulse of each.
  task automatic access(input logic cs, input logic wr, input logic rd,
                        input logic [8:0] a, input logic [31:0] d, input int hold,
                        output int we_n, output int st_n, output int we_i, output int st_i);
    we_n = 0; st_n = 0; we_i = -1; st_i = -1;
    slave_chipselect = cs;
    slave_write      = wr;
    slave_read       = rd;
    slave_address    = a;
    slave_writedata  = d;
    for (int i = 0; i < hold + 3; i++) begin
      if (i == hold) idle_bus();
      step();
      if (sWriteEn === 1'b1) begin
        we_n++;
        if (we_i < 0) we_i = i;
      end
      if (fft_start === 1'b1) begin
        st_n++;
        if (st_i < 0) st_i = i;
      end
    end
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    step();
    n_rst = 1'b1;
  endtask

  initial begin
    n_rst = 1'b0;
    idle_bus();
    slave_address   = '0;
    slave_writedata = '0;

    // Reset state
    step();
    chk("rst_we", 32'(sWriteEn), 32'd0);
    chk("rst_addr", 32'(wAddress), 32'd0);
    chk("rst_data", 32'(fft_init_data), 32'd0);
    chk("rst_start", 32'(fft_start), 32'd0);
    n_rst = 1'b1;
    step();
    step();
    chk("idle_we", 32'(sWriteEn), 32'd0);
    chk("idle_start", 32'(fft_start), 32'd0);

    // Single sample write held 3 cycles
    access(1'b1, 1'b1, 1'b0, 9'd5, 32'h0000ABCD, 3, we_cnt, st_cnt, we_at, st_at);
    chk("s5_we_cnt", 32'(we_cnt), 32'd1);
    chk("s5_we_at", 32'(we_at), 32'd0);
    chk("s5_st_cnt", 32'(st_cnt), 32'd0);
    chk("s5_addr_hold", 32'(wAddress), 32'd5);
    chk("s5_data_hold", 32'(fft_init_data), 32'hABCD);

    // Sweep of the whole sample space from a fresh counter
    do_reset();
    for (int i = 0; i < 256; i++) begin
      access(1'b1, 1'b1, 1'b0, 9'(i), 32'(i), 3, we_cnt, st_cnt, we_at, st_at);
      chk($sformatf("sw%0d_we", i), 32'(we_cnt), 32'd1);
      chk($sformatf("sw%0d_addr", i), 32'(wAddress), 32'(i));
      chk($sformatf("sw%0d_data", i), 32'(fft_init_data), 32'(i));
      chk($sformatf("sw%0d_st", i), 32'(st_cnt), (AUTO && i == 255) ? 32'd1 : 32'd0);
      if (AUTO && i == 255) chk("auto_st_at", 32'(st_at), 32'd1);
    end
    // 257th write: counter was cleared by the auto start (or is saturated), no pulse either way
    access(1'b1, 1'b1, 1'b0, 9'd3, 32'h0000_0033, 3, we_cnt, st_cnt, we_at, st_at);
    chk("w257_we", 32'(we_cnt), 32'd1);
    chk("w257_st", 32'(st_cnt), 32'd0);

    // Control register start
    access(1'b1, 1'b1, 1'b0, 9'h100, 32'h0001_0000, 3, we_cnt, st_cnt, we_at, st_at);
    chk("ctl_st_cnt", 32'(st_cnt), 32'd1);
    chk("ctl_st_at", 32'(st_at), 32'd0);
    chk("ctl_we_cnt", 32'(we_cnt), 32'd0);
    chk("ctl_addr_hold", 32'(wAddress), 32'd3);
    access(1'b1, 1'b1, 1'b0, 9'h100, 32'h0000_FFFF, 3, we_cnt, st_cnt, we_at, st_at);
    chk("ctl_nobit_st", 32'(st_cnt), 32'd0);
    chk("ctl_nobit_we", 32'(we_cnt), 32'd0);

    // Truncation: bit 16 on a sample address must not start the FFT
    access(1'b1, 1'b1, 1'b0, 9'd0, 32'h0001_FFFF, 2, we_cnt, st_cnt, we_at, st_at);
    chk("trunc_we", 32'(we_cnt), 32'd1);
    chk("trunc_data", 32'(fft_init_data), 32'hFFFF);
    chk("trunc_addr", 32'(wAddress), 32'd0);
    chk("trunc_st", 32'(st_cnt), 32'd0);

    // Ignored accesses leave outputs untouched
    access(1'b0, 1'b1, 1'b0, 9'd9, 32'h0000_1111, 2, we_cnt, st_cnt, we_at, st_at);
    chk("nocs_we", 32'(we_cnt), 32'd0);
    chk("nocs_addr", 32'(wAddress), 32'd0);
    access(1'b1, 1'b1, 1'b0, 9'h1FF, 32'h0001_2222, 2, we_cnt, st_cnt, we_at, st_at);
    chk("unmap_we", 32'(we_cnt), 32'd0);
    chk("unmap_st", 32'(st_cnt), 32'd0);
    chk("unmap_data", 32'(fft_init_data), 32'hFFFF);
    access(1'b1, 1'b0, 1'b1, 9'd10, 32'h0001_3333, 2, we_cnt, st_cnt, we_at, st_at);
    chk("rd_we", 32'(we_cnt), 32'd0);
    chk("rd_st", 32'(st_cnt), 32'd0);
    chk("rd_addr", 32'(wAddress), 32'd0);
    access(1'b1, 1'b1, 1'b1, 9'd11, 32'h0000_4444, 2, we_cnt, st_cnt, we_at, st_at);
    chk("rdwr_we", 32'(we_cnt), 32'd1);
    chk("rdwr_addr", 32'(wAddress), 32'd11);
    chk("rdwr_data", 32'(fft_init_data), 32'h4444);

    // Reset in the middle of a held access, then release with the request still up
    slave_chipselect = 1'b1;
    slave_write      = 1'b1;
    slave_address    = 9'd7;
    slave_writedata  = 32'h0000_1234;
    step();
    chk("mid_we", 32'(sWriteEn), 32'd1);
    chk("mid_addr", 32'(wAddress), 32'd7);
    n_rst = 1'b0;
    step();
    chk("mid_rst_we", 32'(sWriteEn), 32'd0);
    chk("mid_rst_addr", 32'(wAddress), 32'd0);
    chk("mid_rst_data", 32'(fft_init_data), 32'd0);
    n_rst = 1'b1;
    step();
    chk("rel_we", 32'(sWriteEn), 32'd1);
    chk("rel_addr", 32'(wAddress), 32'd7);
    chk("rel_data", 32'(fft_init_data), 32'h1234);
    step();
    chk("rel_we_once", 32'(sWriteEn), 32'd0);
    idle_bus();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
